// File: rtl/sr_latch_driver.sv
// ============================================================================
// Module  : sr_latch_driver
// Purpose : Turns a level request into one clean S or R pulse for a NOR SR
//           latch, then a settle window; optional q/p readback check enabled
//           by defining SR_LATCH_DRIVER_READBACK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sr_latch_driver #(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic s_out,
  output logic r_out,
  input  logic q_in,
  input  logic p_in,
  output logic done,
  output logic err,
  output logic cur_q
);

  localparam int c_CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_LOAD  = c_CNT_W'(PULSE_W);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_W);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_val;
  logic                 w_readback_ok;

  assign req_ready = (r_state == ST_IDLE);

`ifdef SR_LATCH_DRIVER_READBACK_EN
  logic [1:0] r_q_sync;
  logic [1:0] r_p_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_sync <= 2'b00;
      r_p_sync <= 2'b00;
    end else begin
      r_q_sync <= {r_q_sync[0], q_in};
      r_p_sync <= {r_p_sync[0], p_in};
    end
  end

  // q==p (forbidden or metastable) can never match (val, ~val).
  assign w_readback_ok = (r_q_sync[1] == r_val) && (r_p_sync[1] == ~r_val);
`else
  logic w_unused_readback;
  assign w_unused_readback = q_in ^ p_in;
  assign w_readback_ok     = 1'b1;
`endif

  // done/err are registered on the SETTLE->CHECK edge so they are visible
  // during the single CHECK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      s_out   <= 1'b0;
      r_out   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cur_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_val   <= req_val;
            s_out   <= req_val;
            r_out   <= ~req_val;
            r_cnt   <= c_PULSE_LOAD;
            r_state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (r_cnt == c_CNT_ONE) begin
            s_out   <= 1'b0;
            r_out   <= 1'b0;
            r_cnt   <= c_SETTLE_LOAD;
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == c_CNT_ONE) begin
            r_cnt   <= '0;
            r_state <= ST_CHECK;
            if (w_readback_ok) begin
              done  <= 1'b1;
              cur_q <= r_val;
            end else begin
              err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        ST_CHECK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
// ============================================================================
// Module  : tb_sr_latch_driver
// Purpose : Directed self-checking bench for sr_latch_driver with a
//           behavioural NOR latch on s_out/r_out.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sr_latch_driver;

  localparam int c_PULSE_W  = 2;
  localparam int c_SETTLE_W = 3;
`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam bit c_RB = 1'b1;
`else
  localparam bit c_RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic req_ready, s_out, r_out, done, err, cur_q;
  logic q_in, p_in;

  logic latch_q = 1'b0;
  logic force_bad = 1'b0;
  logic exp_cur = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural NOR latch; force_bad pins both readbacks low.
  always @(s_out or r_out) begin
    if (s_out)      latch_q = 1'b1;
    else if (r_out) latch_q = 1'b0;
  end
  assign q_in = force_bad ? 1'b0 : latch_q;
  assign p_in = force_bad ? 1'b0 : ~latch_q;

  sr_latch_driver #(.PULSE_W(c_PULSE_W), .SETTLE_W(c_SETTLE_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_val  (req_val),
    .req_ready(req_ready),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .p_in     (p_in),
    .done     (done),
    .err      (err),
    .cur_q    (cur_q)
  );

  always @(negedge clk) begin
    n_checks++;
    if ((s_out & r_out) !== 1'b0) begin
      n_errors++;
      $display("FAIL sr_exclusive t=%0t: s_out=%b r_out=%b, required not both 1", $time, s_out, r_out);
    end
  end

  task automatic test_reset();
    logic [5:0] act;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    act = {s_out, r_out, done, err, req_ready, cur_q};
    n_checks++;
    if (act !== 6'b000010) begin
      n_errors++;
      $display("FAIL reset_held: {s,r,done,err,ready,cur_q}=%b required 000010", act);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    act = {s_out, r_out, done, err, req_ready, cur_q};
    n_checks++;
    if (act !== 6'b000010) begin
      n_errors++;
      $display("FAIL reset_release: {s,r,done,err,ready,cur_q}=%b required 000010", act);
    end
    exp_cur = 1'b0;
  endtask

  // One accepted request, checked every cycle T+1..T+7.
  task automatic run_request(input logic val, input logic rb_bad, input string tag);
    logic fail_rb, next_cur;
    logic [5:0] exp, act;
    fail_rb  = rb_bad & c_RB;
    next_cur = fail_rb ? exp_cur : val;
    force_bad = rb_bad;
    req_val   = val;
    req_valid = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_before_accept: got %b required 1", tag, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp = {(k <= c_PULSE_W) & val, (k <= c_PULSE_W) & ~val,
             (k == 6) & ~fail_rb, (k == 6) & fail_rb, (k == 7),
             (k >= 6) ? next_cur : exp_cur};
      act = {s_out, r_out, done, err, req_ready, cur_q};
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s T+%0d: {s,r,done,err,ready,cur_q}=%b required %b", tag, k, act, exp);
      end
      @(posedge clk);
      #1;
    end
    exp_cur   = next_cur;
    force_bad = 1'b0;
  endtask

  task automatic test_set();
    run_request(1'b1, 1'b0, "set");
  endtask

  task automatic test_reset_value();
    run_request(1'b0, 1'b0, "reset_value");
  endtask

  task automatic test_same_value();
    run_request(1'b0, 1'b0, "same_value");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp, act;
    int j;
    logic v, cq;
    req_val   = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 6) begin j = k;     v = 1'b1; end
      else        begin j = k - 7; v = 1'b0; end
      cq  = (k >= 13) ? 1'b0 : ((k >= 6) ? 1'b1 : exp_cur);
      exp = {(j >= 1 && j <= c_PULSE_W) & v, (j >= 1 && j <= c_PULSE_W) & ~v,
             (j == 6), 1'b0, (j == 0 || j == 7), cq};
      act = {s_out, r_out, done, err, req_ready, cur_q};
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL back_to_back T+%0d: {s,r,done,err,ready,cur_q}=%b required %b", k, act, exp);
      end
      // Changing req_val after the first accept must not alter its pulse.
      if (k == 1) req_val = 1'b0;
      if (k == 8) req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    exp_cur = 1'b0;
  endtask

  task automatic test_readback();
    run_request(1'b1, 1'b1, "readback_bad");
  endtask

  task automatic test_mid_pulse_reset();
    logic [5:0] act;
    req_val   = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (s_out !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_pulse_start: s_out=%b required 1", s_out);
    end
    #2 rst_n = 1'b0;
    #1;
    act = {s_out, r_out, done, err, req_ready, cur_q};
    n_checks++;
    if (act !== 6'b000010) begin
      n_errors++;
      $display("FAIL mid_reset_async: {s,r,done,err,ready,cur_q}=%b required 000010", act);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cur = 1'b0;
    for (int k = 0; k < 8; k++) begin
      act = {s_out, r_out, done, err, req_ready, cur_q};
      n_checks++;
      if (act !== 6'b000010) begin
        n_errors++;
        $display("FAIL mid_reset_after cycle %0d: {s,r,done,err,ready,cur_q}=%b required 000010", k, act);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_set();
    test_reset_value();
    test_same_value();
    test_back_to_back();
    test_readback();
    test_mid_pulse_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
